t_toggle_decoder: RTL and testbench

T_TOGGLE_DECODER -- requirements
Module: t_toggle_decoder

---
 rtl/t_toggle_decoder_pkg.sv | 21 ++
 rtl/t_toggle_decoder_bit_dec.sv | 31 +++
 rtl/t_toggle_decoder.sv | 94 +++++++++
 tb/tb_t_toggle_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/t_toggle_decoder_pkg.sv
// ============================================================================
//  Module  : t_toggle_decoder_pkg
//  Brief   : Shared constants and helpers for the T-flip-flop line decoder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package t_toggle_decoder_pkg;

    localparam int DATA_W_DEF = 8;

    // Counter must index every bit position 0..DATA_W-1.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DATA_W_DEF);

endpackage

`default_nettype wire

// File: rtl/t_toggle_decoder_bit_dec.sv
// ============================================================================
//  Module  : toggle_bit_dec
//  Brief   : Recovers one original bit per enabled sample from a toggle line.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module toggle_bit_dec (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic q_in,
    output logic t_out
);

    logic r_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_q <= 1'b0;
        end else if (en) begin
            r_prev_q <= q_in;
        end
    end

    // A change of level since the last consumed sample means the source bit was 1.
    assign t_out = q_in ^ r_prev_q;

endmodule

`default_nettype wire

// File: rtl/t_toggle_decoder.sv
// ============================================================================
//  Module  : t_toggle_decoder
//  Brief   : Assembles decoded toggle bits into DATA_W words with a one-word
//            valid/ready output buffer and a sticky overrun flag.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module t_toggle_decoder
    import t_toggle_decoder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              q_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    input  logic              clr_ovr
);

    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(DATA_W - 1);

    logic              w_t;
    logic [DATA_W-1:0] w_word;
    logic              w_complete;
    logic              w_load;
    logic              w_drop;

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_ovr;

    toggle_bit_dec u_bit_dec (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .q_in  (q_in),
        .t_out (w_t)
    );

    // The word as it will look once the current bit has shifted in, so the
    // completing bit is captured without waiting for the shift register.
    assign w_word     = {w_t, r_shift[DATA_W-1:1]};
    assign w_complete = en && (r_cnt == c_LAST_IDX);
    assign w_load     = w_complete && (!r_valid || data_ready);
    assign w_drop     = w_complete && r_valid && !data_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (en) begin
            r_shift <= w_word;
            r_cnt   <= (r_cnt == c_LAST_IDX) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (r_valid && data_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_t_toggle_decoder.sv
// ============================================================================
//  Module  : tb_t_toggle_decoder
//  Brief   : Directed and random checks of t_toggle_decoder against a model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_t_toggle_decoder;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              q_in = 1'b0;
    logic              data_ready = 1'b0;
    logic              clr_ovr = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int           m_bits[$];
    logic         m_prev;
    int unsigned  m_out;
    logic         m_valid;
    logic         m_ovr;

    t_toggle_decoder #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .q_in       (q_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_prev  = 1'b0;
        m_out   = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Model: a level change between consumed samples is a 1; every DATA_W
    // bits form a word, first bit in the LSB.
    task automatic model_step(input logic s_rst, input logic s_en, input logic s_q,
                              input logic s_rdy, input logic s_clr);
        bit          done;
        int unsigned word;
        done = 0;
        word = 0;
        if (!s_rst) begin
            model_reset();
            return;
        end
        if (s_en) begin
            m_bits.push_back((s_q != m_prev) ? 1 : 0);
            m_prev = s_q;
            if (m_bits.size() == DATA_W) begin
                for (int i = 0; i < DATA_W; i++) word += m_bits[i] * (1 << i);
                m_bits.delete();
                done = 1;
            end
        end
        if (s_clr) m_ovr = 1'b0;
        if (done) begin
            if (!m_valid || s_rdy) begin
                m_out   = word;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && s_rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic s_rst, input logic s_en, input logic s_q,
                         input logic s_rdy, input logic s_clr);
        @(negedge clk);
        rst = s_rst; en = s_en; q_in = s_q; data_ready = s_rdy; clr_ovr = s_clr;
        @(posedge clk);
        model_step(s_rst, s_en, s_q, s_rdy, s_clr);
        #1;
        check_val("data_out", 32'(data_out), m_out);
        check_val("data_valid", 32'(data_valid), 32'(m_valid));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // Toggle-encode a word from the model's current line level; optional idle
    // gaps with a wandering q_in, and data_ready raised on the last bit.
    task automatic send_word(input logic [DATA_W-1:0] w, input bit gaps, input bit rdy_last);
        logic lvl;
        lvl = m_prev;
        for (int i = 0; i < DATA_W; i++) begin
            if (gaps) begin
                cycle(1'b1, 1'b0, ~lvl, 1'b0, 1'b0);
                cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            lvl = lvl ^ w[i];
            cycle(1'b1, 1'b1, lvl, (i == DATA_W - 1) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        do_reset();
        do_reset();
        check_val("rst_valid", 32'(data_valid), 32'd0);
        check_val("rst_data", 32'(data_out), 32'd0);

        send_word(8'hA5, 0, 0);
        check_val("dec_valid", 32'(data_valid), 32'd1);
        check_val("dec_data", 32'(data_out), 32'hA5);

        do_reset();
        send_word(8'hA5, 1, 0);
        check_val("gap_data", 32'(data_out), 32'hA5);

        do_reset();
        send_word(8'hA5, 0, 0);
        send_word(8'h3C, 0, 1);
        check_val("b2b_valid", 32'(data_valid), 32'd1);
        check_val("b2b_data", 32'(data_out), 32'h3C);
        check_val("b2b_ovr", 32'(overrun), 32'd0);

        do_reset();
        send_word(8'hA5, 0, 0);
        send_word(8'h3C, 0, 0);
        check_val("ovr_data", 32'(data_out), 32'hA5);
        check_val("ovr_set", 32'(overrun), 32'd1);
        cycle(1'b1, 1'b0, m_prev, 1'b0, 1'b1);
        check_val("ovr_clr", 32'(overrun), 32'd0);

        do_reset();
        send_word(8'hFF, 0, 0);
        send_word(8'h81, 0, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("rprio_valid", 32'(data_valid), 32'd0);
        check_val("rprio_ovr", 32'(overrun), 32'd0);
        check_val("rprio_data", 32'(data_out), 32'd0);

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'(i & 1), 1'b0, 1'b0);
        do_reset();
        send_word(8'hA5, 0, 0);
        check_val("midrst_data", 32'(data_out), 32'hA5);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
